// File: rtl/arbitro_matriculas_pkg.sv
// Shared definitions for the plate arbiter: FSM states and plate constants.
package arbitro_matriculas_pkg;

    localparam int PLATE_W = 24;
    localparam logic [PLATE_W-1:0] PLATE_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        HOLD  = 2'd2
    } estado_t;

endpackage

// File: rtl/arbitro_rr.sv
// Two-way round-robin grant. A lone requester always wins; on a tie the pointer
// decides, and every granted advance moves the pointer to the loser.
module arbitro_rr (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       avanca,
    output logic [1:0] grant
);

    logic ptr_reg;

    always_comb begin
        grant = 2'b00;
        if (req0 && req1) begin
            grant = ptr_reg ? 2'b10 : 2'b01;
        end else if (req0) begin
            grant = 2'b01;
        end else if (req1) begin
            grant = 2'b10;
        end
    end

    // grant[0] set means camera 0 won, so camera 1 gets priority next tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= 1'b0;
        end else if (avanca && (grant != 2'b00)) begin
            ptr_reg <= grant[0];
        end
    end

endmodule

// File: rtl/arbitro_matriculas.sv
// Arbitrates entrance/exit camera plates onto one history-store write port.
// Optional macro DUP_FILTER_EN drops a plate equal to the last one written.
module arbitro_matriculas
    import arbitro_matriculas_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic [PLATE_W-1:0] matr0,
    output logic               ack0,
    input  logic               req1,
    input  logic [PLATE_W-1:0] matr1,
    output logic               ack1,
    output logic [PLATE_W-1:0] matrout,
    output logic               matrval,
    output logic               origem,
    output logic               ocupado,
    output logic [CNT_W-1:0]   descartadas
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    estado_t             state_reg, state_next;
    logic [HOLD_W-1:0]   hold_cnt_reg;
    logic [PLATE_W-1:0]  matrout_reg;
    logic                origem_reg;
    logic [1:0]          grant;
    logic                pedido;
    logic                concede;
    logic                em_write;
    logic                hold_fim;
    logic                placa_nula;
    logic                rejeita;

    assign pedido   = req0 || req1;
    assign concede  = (state_reg == IDLE) && pedido;
    assign em_write = (state_reg == WRITE);
    assign hold_fim = (hold_cnt_reg == HOLD_W'(HOLD_CYCLES - 1));

    arbitro_rr u_rr (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .req1   (req1),
        .avanca (concede),
        .grant  (grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (pedido) state_next = WRITE;
            WRITE:   state_next = (HOLD_CYCLES == 0) ? IDLE : HOLD;
            HOLD:    if (hold_fim) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Counter runs 0..HOLD_CYCLES-1 while in HOLD, restarted by each WRITE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_reg <= '0;
        end else if (em_write) begin
            hold_cnt_reg <= '0;
        end else if (state_reg == HOLD) begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            matrout_reg <= PLATE_ZERO;
            origem_reg  <= 1'b0;
        end else if (concede) begin
            matrout_reg <= grant[1] ? matr1 : matr0;
            origem_reg  <= grant[1];
        end
    end

    assign placa_nula = (matrout_reg == PLATE_ZERO);

`ifdef DUP_FILTER_EN
    logic [PLATE_W-1:0] ultima_reg;
    logic [CNT_W-1:0]   desc_reg;
    logic               duplicada;

    assign duplicada = !placa_nula && (matrout_reg == ultima_reg);

    // Only a strobed plate becomes the reference for the next comparison
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ultima_reg <= PLATE_ZERO;
            desc_reg   <= '0;
        end else if (em_write) begin
            if (duplicada) begin
                if (desc_reg != '1) begin
                    desc_reg <= desc_reg + 1'b1;
                end
            end else if (!placa_nula) begin
                ultima_reg <= matrout_reg;
            end
        end
    end

    assign rejeita     = placa_nula || duplicada;
    assign descartadas = desc_reg;
`else
    assign rejeita     = placa_nula;
    assign descartadas = '0;
`endif

    assign ack0    = em_write && !origem_reg;
    assign ack1    = em_write && origem_reg;
    assign matrval = em_write && !rejeita;
    assign matrout = matrout_reg;
    assign origem  = origem_reg;
    assign ocupado = (state_reg != IDLE);

endmodule

// File: tb/tb_arbitro_matriculas.sv
// Self-checking bench for arbitro_matriculas: cycle model plus directed scenarios.
module tb_arbitro_matriculas;

    localparam int H  = 4;
    localparam int CW = 8;
`ifdef DUP_FILTER_EN
    localparam bit DUP = 1'b1;
`else
    localparam bit DUP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0;
    logic          req1 = 1'b0;
    logic [23:0]   matr0 = 24'h0;
    logic [23:0]   matr1 = 24'h0;
    logic          ack0, ack1, matrval, origem, ocupado;
    logic [23:0]   matrout;
    logic [CW-1:0] descartadas;

    arbitro_matriculas #(.HOLD_CYCLES(H), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0        (req0),
        .matr0       (matr0),
        .ack0        (ack0),
        .req1        (req1),
        .matr1       (matr1),
        .ack1        (ack1),
        .matrout     (matrout),
        .matrval     (matrval),
        .origem      (origem),
        .ocupado     (ocupado),
        .descartadas (descartadas)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string nome, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at t=%0t", nome, act, exp, $time);
        end
    endtask

    // Model: a grant at edge g means one WRITE cycle after g, busy until edge g+1+H,
    // and the next grant no earlier than edge g+2+H.
    int          cyc = 0;
    int          g_edge = -1000;
    int          next_free = 0;
    int          m_cnt = 0;
    bit          m_ptr, m_org, m_val, m_w, pend_dup, pend_str;
    logic [23:0] m_out, m_last;

    task automatic model_step();
        if (rst) begin
            cyc = 0; g_edge = -1000; next_free = 0; m_cnt = 0;
            m_ptr = 0; m_org = 0; m_val = 0; pend_dup = 0; pend_str = 0;
            m_out = 24'h0; m_last = 24'h0;
        end else begin
            cyc++;
            if (pend_dup && m_cnt < (1 << CW) - 1) m_cnt++;
            if (pend_str) m_last = m_out;
            pend_dup = 0;
            pend_str = 0;
            if (cyc >= next_free && (req0 || req1)) begin
                m_w       = (req0 && req1) ? m_ptr : req1;
                m_out     = m_w ? matr1 : matr0;
                m_org     = m_w;
                m_ptr     = !m_w;
                g_edge    = cyc;
                next_free = cyc + 2 + H;
                pend_dup  = DUP && (m_out != 24'h0) && (m_out == m_last);
                m_val     = (m_out != 24'h0) && !pend_dup;
                pend_str  = m_val;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        check("ack0",        32'(ack0),        32'(cyc == g_edge && !m_org));
        check("ack1",        32'(ack1),        32'(cyc == g_edge && m_org));
        check("matrval",     32'(matrval),     32'(cyc == g_edge && m_val));
        check("matrout",     32'(matrout),     32'(m_out));
        check("origem",      32'(origem),      32'(m_org));
        check("ocupado",     32'(ocupado),     32'(cyc >= g_edge && cyc <= next_free - 2));
        check("descartadas", 32'(descartadas), 32'(m_cnt));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Camera handshake: raise request, wait (bounded) for its Ack, then drop it
    task automatic pedir(input bit cam, input logic [23:0] placa, output bit viu_val, output int lat);
        bit ok;
        @(negedge clk);
        if (cam) begin req1 = 1'b1; matr1 = placa; end
        else     begin req0 = 1'b1; matr0 = placa; end
        ok = 0; viu_val = 0; lat = -1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (cam ? ack1 : ack0) begin
                ok = 1; viu_val = matrval; lat = i + 1;
            end
        end
        check("ack_seen", 32'(ok), 32'd1);
        if (cam) req1 = 1'b0; else req0 = 1'b0;
    endtask

    bit          v1, v2;
    int          lat;
    int          t_ack [4];
    bit          o_ack [4];
    int          n_ack;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_matrout", 32'(matrout), 32'h0);
        check("rst_desc",    32'(descartadas), 32'h0);

        // single entrance request
        pedir(1'b0, 24'h1A2B3C, v1, lat);
        check("t1_val",     32'(v1), 32'd1);
        check("t1_lat",     32'(lat), 32'd1);
        check("t1_matrout", 32'(matrout), 32'h1A2B3C);
        check("t1_origem",  32'(origem), 32'd0);
        repeat (H + 2) @(negedge clk);

        // both held after reset: alternate 0,1,0,1 every 6 cycles
        do_reset();
        @(negedge clk);
        matr0 = 24'h111111; matr1 = 24'h222222;
        req0 = 1'b1; req1 = 1'b1;
        n_ack = 0;
        for (int c = 0; c < 60 && n_ack < 4; c++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                t_ack[n_ack] = c;
                o_ack[n_ack] = ack1;
                n_ack++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        check("t2_nack", 32'(n_ack), 32'd4);
        for (int k = 0; k < 4; k++) check("t2_order", 32'(o_ack[k]), 32'(k % 2));
        for (int k = 1; k < 4; k++) check("t2_spacing", 32'(t_ack[k] - t_ack[k-1]), 32'd6);
        repeat (H + 2) @(negedge clk);

        // duplicate plate twice
        pedir(1'b0, 24'h0A0B0C, v1, lat);
        pedir(1'b0, 24'h0A0B0C, v2, lat);
        check("t3_first_val",  32'(v1), 32'd1);
        check("t3_second_val", 32'(v2), DUP ? 32'd0 : 32'd1);
        @(negedge clk);
        check("t3_desc", 32'(descartadas), DUP ? 32'd1 : 32'd0);

        // zero plate from exit camera
        pedir(1'b1, 24'h000000, v1, lat);
        check("t4_val", 32'(v1), 32'd0);
        @(negedge clk);
        check("t4_desc", 32'(descartadas), DUP ? 32'd1 : 32'd0);
        repeat (H + 2) @(negedge clk);

        // asynchronous reset during HOLD with a pending exit request
        pedir(1'b0, 24'h123456, v1, lat);
        @(negedge clk);
        @(negedge clk);
        req1 = 1'b1; matr1 = 24'h654321;
        #2 rst = 1'b1;
        #1;
        check("t5_ocupado", 32'(ocupado), 32'd0);
        check("t5_matrout", 32'(matrout), 32'h0);
        check("t5_origem",  32'(origem), 32'd0);
        check("t5_acks",    32'({ack0, ack1, matrval}), 32'd0);
        check("t5_desc",    32'(descartadas), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t5_ack1",    32'(ack1), 32'd1);
        check("t5_val",     32'(matrval), 32'd1);
        check("t5_matrout", 32'(matrout), 32'h654321);
        req1 = 1'b0;
        repeat (H + 2) @(negedge clk);

        // one fresh plate then 256 duplicates: counter saturates
        for (int k = 0; k < 257; k++) pedir(1'b0, 24'hABCDEF, v1, lat);
        @(negedge clk);
        check("t6_sat", 32'(descartadas), DUP ? 32'hFF : 32'h0);
        repeat (H + 2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
